// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 target bridging a host to a register interface: command byte (R/W + addr), then dsz data bits.
// Optional SPI_CIPO_HIZ_EN: release spi_cipo to high-Z while the synchronised chip select is high.
module spi_reg_peripheral #(
    parameter int dsz = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           spi_clk,
    input  logic           spi_cs,
    input  logic           spi_copi,
    output logic           spi_cipo,
    output logic           we,
    output logic           re,
    output logic [6:0]     addr,
    output logic [dsz-1:0] wdat,
    input  logic [dsz-1:0] rdat,
    output logic           mosi_cnt_is_zero,
    output logic           spi_reset
);

    localparam int CW = $clog2(dsz + 9);
    localparam logic [CW-1:0] CNT_CMD_LAST  = CW'(7);
    localparam logic [CW-1:0] CNT_CMD       = CW'(8);
    localparam logic [CW-1:0] CNT_DATA_LAST = CW'(dsz + 7);
    localparam logic [CW-1:0] CNT_END       = CW'(dsz + 8);

    logic [2:0]     sclk_sync_r;
    logic [2:0]     cs_sync_r;
    logic [1:0]     copi_sync_r;
    logic [CW-1:0]  cnt_r;
    logic [dsz-2:0] in_sr_r;
    logic [dsz-1:0] out_sr_r;
    logic           rw_r;
    logic           load_r;
    logic           cipo_r;
    logic           we_r;
    logic           re_r;
    logic           spi_reset_r;
    logic [6:0]     addr_r;
    logic [dsz-1:0] wdat_r;

    logic sclk_rise_s;
    logic sclk_fall_s;
    logic cs_rise_s;
    logic cs_s;
    logic copi_s;

    assign sclk_rise_s = sclk_sync_r[1] & ~sclk_sync_r[2];
    assign sclk_fall_s = ~sclk_sync_r[1] & sclk_sync_r[2];
    assign cs_rise_s   = cs_sync_r[1] & ~cs_sync_r[2];
    assign cs_s        = cs_sync_r[1];
    assign copi_s      = copi_sync_r[1];

    // Two-stage synchronisers plus one history stage for edge detection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sclk_sync_r <= 3'b000;
            cs_sync_r   <= 3'b111;
            copi_sync_r <= 2'b00;
        end else begin
            sclk_sync_r <= {sclk_sync_r[1:0], spi_clk};
            cs_sync_r   <= {cs_sync_r[1:0], spi_cs};
            copi_sync_r <= {copi_sync_r[0], spi_copi};
        end
    end

    // Frame engine: bit counter, shifters, command decode and strobes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r       <= '0;
            in_sr_r     <= '0;
            out_sr_r    <= '0;
            rw_r        <= 1'b0;
            load_r      <= 1'b0;
            cipo_r      <= 1'b0;
            we_r        <= 1'b0;
            re_r        <= 1'b0;
            spi_reset_r <= 1'b0;
            addr_r      <= 7'h00;
            wdat_r      <= '0;
        end else begin
            we_r        <= 1'b0;
            re_r        <= 1'b0;
            load_r      <= 1'b0;
            spi_reset_r <= cs_rise_s;
            if (cs_s) begin
                cnt_r    <= '0;
                in_sr_r  <= '0;
                out_sr_r <= '0;
                rw_r     <= 1'b0;
                cipo_r   <= 1'b0;
            end else begin
                if (sclk_rise_s && (cnt_r != CNT_END)) begin
                    cnt_r   <= cnt_r + CW'(1);
                    in_sr_r <= {in_sr_r[dsz-3:0], copi_s};
                    // Completing the command byte: in_sr_r[6] holds the R/W bit.
                    if (cnt_r == CNT_CMD_LAST) begin
                        addr_r <= {in_sr_r[5:0], copi_s};
                        rw_r   <= in_sr_r[6];
                        re_r   <= in_sr_r[6];
                        load_r <= in_sr_r[6];
                    end else if ((cnt_r == CNT_DATA_LAST) && !rw_r) begin
                        wdat_r <= {in_sr_r, copi_s};
                        we_r   <= 1'b1;
                    end else begin
                        wdat_r <= wdat_r;
                    end
                end else begin
                    cnt_r <= cnt_r;
                end
                // Read data is captured the cycle after re; it reaches the pin on the following falling edges.
                if (load_r) begin
                    out_sr_r <= rdat;
                end else if (sclk_fall_s && rw_r && (cnt_r >= CNT_CMD) && (cnt_r != CNT_END)) begin
                    cipo_r   <= out_sr_r[dsz-1];
                    out_sr_r <= {out_sr_r[dsz-2:0], 1'b0};
                end else begin
                    out_sr_r <= out_sr_r;
                end
            end
        end
    end

    assign we               = we_r;
    assign re               = re_r;
    assign addr             = addr_r;
    assign wdat             = wdat_r;
    assign spi_reset        = spi_reset_r;
    assign mosi_cnt_is_zero = (cnt_r == '0);

`ifdef SPI_CIPO_HIZ_EN
    assign spi_cipo = cs_s ? 1'bz : cipo_r;
`else
    assign spi_cipo = cs_s ? 1'b0 : cipo_r;
`endif

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Directed bench for spi_reg_peripheral (dsz=16, spi_clk = clk/8).
module tb_spi_reg_peripheral;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        spi_clk = 1'b0;
    logic        spi_cs = 1'b1;
    logic        spi_copi = 1'b0;
    logic        spi_cipo;
    logic        we;
    logic        re;
    logic [6:0]  addr;
    logic [15:0] wdat;
    logic [15:0] rdat = 16'h0000;
    logic        mosi_cnt_is_zero;
    logic        spi_reset;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    int we_cnt = 0;
    int re_cnt = 0;
    int rst_cnt = 0;
    int both_cnt = 0;

    spi_reg_peripheral #(.dsz(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .spi_clk          (spi_clk),
        .spi_cs           (spi_cs),
        .spi_copi         (spi_copi),
        .spi_cipo         (spi_cipo),
        .we               (we),
        .re               (re),
        .addr             (addr),
        .wdat             (wdat),
        .rdat             (rdat),
        .mosi_cnt_is_zero (mosi_cnt_is_zero),
        .spi_reset        (spi_reset)
    );

    always #5 clk = ~clk;

    // Pulse counters; a strobe held for several cycles counts several times.
    always @(posedge clk) begin
        if (we) we_cnt <= we_cnt + 1;
        if (re) re_cnt <= re_cnt + 1;
        if (spi_reset) rst_cnt <= rst_cnt + 1;
        if (we && re) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Host side of one mode-0 frame; bits past the 24th carry the value 'extra'.
    task automatic spi_frame(input logic [7:0] cmd, input logic [15:0] data, input int nbits,
                             input logic extra, output logic [15:0] miso);
        logic [23:0] frame;
        frame = {cmd, data};
        miso = 16'h0000;
        @(negedge clk);
        spi_cs = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_copi = (i < 24) ? frame[23-i] : extra;
            repeat (4) @(negedge clk);
            spi_clk = 1'b1;
            if (i >= 8 && i < 24) miso[23-i] = spi_cipo;
            repeat (4) @(negedge clk);
            spi_clk = 1'b0;
        end
        repeat (8) @(negedge clk);
        spi_cs = 1'b1;
        spi_copi = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        logic [15:0] miso;
        int we0, re0, rst0;

        // Held in reset while the host runs a full frame.
        repeat (4) @(negedge clk);
        check("rst_cnt_zero", {31'd0, mosi_cnt_is_zero}, 32'd1);
        rdat = 16'hA5C3;
        spi_frame(8'h85, 16'h0000, 24, 1'b0, miso);
        check("rst_we", we_cnt, 32'd0);
        check("rst_re", re_cnt, 32'd0);
        check("rst_spi_reset", rst_cnt, 32'd0);
        check("rst_cipo", miso, 32'h0000);
        check("rst_addr", addr, 32'h00);
        check("rst_wdat", wdat, 32'h0000);
        check("rst_cnt_zero_after", {31'd0, mosi_cnt_is_zero}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);

        // Write 0x05 <- 0xBEEF
        we0 = we_cnt; re0 = re_cnt; rst0 = rst_cnt;
        spi_frame(8'h05, 16'hBEEF, 24, 1'b0, miso);
        check("wr_we_pulses", we_cnt - we0, 32'd1);
        check("wr_re_pulses", re_cnt - re0, 32'd0);
        check("wr_addr", addr, 32'h05);
        check("wr_wdat", wdat, 32'hBEEF);
        check("wr_spi_reset", rst_cnt - rst0, 32'd1);
        check("wr_cipo_quiet", miso, 32'h0000);
        check("wr_cnt_zero", {31'd0, mosi_cnt_is_zero}, 32'd1);

        // Read 0x85 -> host receives 0xA5C3
        we0 = we_cnt; re0 = re_cnt; rst0 = rst_cnt;
        spi_frame(8'h85, 16'h0000, 24, 1'b0, miso);
        check("rd_re_pulses", re_cnt - re0, 32'd1);
        check("rd_we_pulses", we_cnt - we0, 32'd0);
        check("rd_addr", addr, 32'h05);
        check("rd_miso", miso, 32'hA5C3);
        check("rd_wdat_held", wdat, 32'hBEEF);
        check("rd_spi_reset", rst_cnt - rst0, 32'd1);

        // Abort a write of 0x03 <- 0x1234 after 12 bits
        we0 = we_cnt; re0 = re_cnt; rst0 = rst_cnt;
        spi_frame(8'h03, 16'h1234, 12, 1'b0, miso);
        check("ab_we_pulses", we_cnt - we0, 32'd0);
        check("ab_spi_reset", rst_cnt - rst0, 32'd1);
        check("ab_cnt_zero", {31'd0, mosi_cnt_is_zero}, 32'd1);
        check("ab_wdat_held", wdat, 32'hBEEF);
        check("ab_addr", addr, 32'h03);

        // Back-to-back writes
        we0 = we_cnt;
        spi_frame(8'h01, 16'h0001, 24, 1'b0, miso);
        check("b2b1_we_pulses", we_cnt - we0, 32'd1);
        check("b2b1_addr", addr, 32'h01);
        check("b2b1_wdat", wdat, 32'h0001);
        we0 = we_cnt;
        spi_frame(8'h02, 16'h0002, 24, 1'b0, miso);
        check("b2b2_we_pulses", we_cnt - we0, 32'd1);
        check("b2b2_addr", addr, 32'h02);
        check("b2b2_wdat", wdat, 32'h0002);

        // 30 clocks in a write frame; the 6 extra bits are ones and must be ignored
        we0 = we_cnt; re0 = re_cnt;
        spi_frame(8'h07, 16'hCAFE, 30, 1'b1, miso);
        check("ovr_we_pulses", we_cnt - we0, 32'd1);
        check("ovr_re_pulses", re_cnt - re0, 32'd0);
        check("ovr_addr", addr, 32'h07);
        check("ovr_wdat", wdat, 32'hCAFE);
        check("ovr_cnt_zero", {31'd0, mosi_cnt_is_zero}, 32'd1);

        check("we_re_overlap", both_cnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
